// File: rtl/shiftreg_seq_ctrl.sv
// Command sequencer for the 8-bit multi-op shift register: expands one accepted
// command into a per-cycle op stream (load, N shift/rotate steps, or preset).
module shiftreg_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] sr_q,
    output logic [2:0]       sr_op,
    output logic [WIDTH-1:0] sr_datain,
    output logic             sr_sin,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_PRESET = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_ZERO + 1'b1;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] len_r;
    logic             done_r;

    logic [2:0]       sr_op_s;
    logic [WIDTH-1:0] sr_datain_s;
    logic             sr_sin_s;
    logic             busy_s;

    // Sequencer state, step counter, latched command and completion pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            mode_r  <= 2'b00;
            data_r  <= {WIDTH{1'b0}};
            len_r   <= CNT_ZERO;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        mode_r <= cmd_mode;
                        data_r <= cmd_data;
                        len_r  <= cmd_len;
                        case (cmd_mode)
                            2'b00, 2'b01: state_r <= ST_LOAD;
                            2'b10: begin
                                // A zero-step rotate completes without leaving IDLE
                                if (cmd_len != CNT_ZERO) begin
                                    state_r <= ST_SHIFT;
                                    cnt_r   <= cmd_len;
                                end else begin
                                    state_r <= ST_IDLE;
                                    done_r  <= 1'b1;
                                end
                            end
                            2'b11:   state_r <= ST_PRESET;
                            default: state_r <= ST_IDLE;
                        endcase
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (len_r != CNT_ZERO) begin
                        state_r <= ST_SHIFT;
                        cnt_r   <= len_r;
                    end else begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_PRESET: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b1;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Op decode: every non-active cycle reloads sr_q so the register holds its value
    always_comb begin
        sr_op_s     = 3'b110;
        sr_datain_s = sr_q;
        sr_sin_s    = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_LOAD: begin
                sr_datain_s = data_r;
                busy_s      = 1'b1;
            end
            ST_SHIFT: begin
                busy_s = 1'b1;
                case (mode_r)
                    2'b00: begin
                        sr_op_s  = 3'b001;
                        sr_sin_s = ser_in;
                    end
                    2'b01:   sr_op_s = 3'b010;
                    2'b10:   sr_op_s = 3'b111;
                    default: sr_op_s = 3'b110;
                endcase
            end
            ST_PRESET: begin
                sr_op_s = 3'b000;
                busy_s  = 1'b1;
            end
            default: begin
                sr_op_s = 3'b110;
                busy_s  = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign sr_op     = sr_op_s;
    assign sr_datain = sr_datain_s;
    assign sr_sin    = sr_sin_s;
    assign busy      = busy_s;
    assign done      = done_r;

endmodule
